// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared fetch constants: state encoding, NOP, field positions, opcodes
package riscv_fetch_pkg;

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNC3_LSB  = 12;
    localparam int FUNC3_MSB  = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int FUNC7_LSB  = 25;
    localparam int FUNC7_MSB  = 31;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - imem handshake and execute-side signals of the fetch unit
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_src;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        trap_valid;
    logic [31:0] trap_epc;

    modport master (
        output imem_req, imem_addr, input imem_ack, imem_rdata,
        output instr_valid, input instr_ready, pc_src, imm_ext,
        output pc, pc_plus4, instr, opcode, func3, func7, rd, rs1, rs2,
        output trap_valid, trap_epc
    );

    modport slave (
        input imem_req, imem_addr, output imem_ack, imem_rdata,
        input instr_valid, output instr_ready, pc_src, imm_ext,
        input pc, pc_plus4, instr, opcode, func3, func7, rd, rs1, rs2,
        input trap_valid, trap_epc
    );
endinterface

// File: rtl/fetch_pc_next.sv
// rtl/fetch_pc_next.sv - combinational next-PC select, +4 and +imm adders, misalign detect
module fetch_pc_next (
    input  logic [31:0] pc,
    input  logic        pc_src,
    input  logic [31:0] imm_ext,
    output logic [31:0] pc_plus4,
    output logic [31:0] target,
    output logic        misaligned
);
    assign pc_plus4   = pc + 32'd4;
    assign target     = pc_src ? (pc + imm_ext) : pc_plus4;
    assign misaligned = |target[1:0];
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch FSM and PC/instruction registers; optional FETCH_MISALIGN_TRAP_EN
module instr_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic clk,
    input  logic rst_n,
    instr_fetch_unit_if.master bus
);
    logic [1:0]  state;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        misaligned;
    logic        accept;

    fetch_pc_next u_pc_next (
        .pc         (pc_q),
        .pc_src     (bus.pc_src),
        .imm_ext    (bus.imm_ext),
        .pc_plus4   (pc_plus4),
        .target     (target),
        .misaligned (misaligned)
    );

    assign accept = (state == ST_HOLD) && bus.instr_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        trap_valid_q;
    logic [31:0] trap_epc_q;

    assign next_pc = misaligned ? TRAP_VEC : target;

    // Trap pulse lasts one cycle; the faulting target is kept until the next trap or reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trap_valid_q <= 1'b0;
            trap_epc_q   <= 32'h0;
        end else begin
            trap_valid_q <= accept && misaligned;
            if (accept && misaligned)
                trap_epc_q <= target;
        end
    end

    assign bus.trap_valid = trap_valid_q;
    assign bus.trap_epc   = trap_epc_q;
`else
    logic unused_trap;

    assign next_pc        = {target[31:2], 2'b00};
    assign unused_trap    = ^{TRAP_VEC, misaligned};
    assign bus.trap_valid = 1'b0;
    assign bus.trap_epc   = 32'h0;
`endif

    // Fetch FSM: request until ack, hold the word until the execute side accepts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_RESET;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            case (state)
                ST_RESET: state <= ST_REQ;
                ST_REQ: begin
                    if (bus.imem_ack) begin
                        instr_q <= bus.imem_rdata;
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        pc_q  <= next_pc;
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_RESET;
            endcase
        end
    end

    assign bus.imem_req    = (state == ST_REQ);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state == ST_HOLD);
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign bus.func3       = instr_q[FUNC3_MSB:FUNC3_LSB];
    assign bus.func7       = instr_q[FUNC7_MSB:FUNC7_LSB];
    assign bus.rd          = instr_q[RD_MSB:RD_LSB];
    assign bus.rs1         = instr_q[RS1_MSB:RS1_LSB];
    assign bus.rs2         = instr_q[RS2_MSB:RS2_LSB];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed and randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] TVEC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_epc = 32'h0;

    instr_fetch_unit_if bus ();

    instr_fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait states then ack; fields are re-sliced from the raw word here.
    task automatic do_fetch(input int waits, input logic [31:0] word);
        for (int w = 0; w < waits; w++) begin
            bus.imem_ack    = 1'b0;
            bus.imem_rdata  = $urandom;
            bus.instr_ready = 1'($urandom);
            tick();
            check("wait_valid", {31'h0, bus.instr_valid}, 32'h0);
            check("wait_req", {31'h0, bus.imem_req}, 32'h1);
            check("wait_addr", bus.imem_addr, exp_pc);
        end
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = word;
        bus.instr_ready = 1'b0;
        tick();
        bus.imem_ack = 1'b0;
        check("f_valid", {31'h0, bus.instr_valid}, 32'h1);
        check("f_req", {31'h0, bus.imem_req}, 32'h0);
        check("f_instr", bus.instr, word);
        check("f_opcode", {25'h0, bus.opcode}, word & 32'h7F);
        check("f_func3", {29'h0, bus.func3}, (word >> 12) & 32'h7);
        check("f_func7", {25'h0, bus.func7}, word >> 25);
        check("f_rd", {27'h0, bus.rd}, (word >> 7) & 32'h1F);
        check("f_rs1", {27'h0, bus.rs1}, (word >> 15) & 32'h1F);
        check("f_rs2", {27'h0, bus.rs2}, (word >> 20) & 32'h1F);
        check("f_pc", bus.pc, exp_pc);
        check("f_pc_plus4", bus.pc_plus4, exp_pc + 32'd4);
    endtask

    task automatic do_accept(input logic s, input logic [31:0] imm);
        logic [31:0] tgt;
        logic        trap;
        bus.instr_ready = 1'b1;
        bus.pc_src      = s;
        bus.imm_ext     = imm;
        tick();
        bus.instr_ready = 1'b0;
        bus.pc_src      = 1'($urandom);
        bus.imm_ext     = $urandom;
        tgt = s ? exp_pc + imm : exp_pc + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap = (tgt % 4) != 0;
        if (trap) begin
            exp_pc  = TVEC;
            exp_epc = tgt;
        end else begin
            exp_pc = tgt;
        end
`else
        trap   = 1'b0;
        exp_pc = tgt - (tgt % 4);
`endif
        check("acc_addr", bus.imem_addr, exp_pc);
        check("acc_req", {31'h0, bus.imem_req}, 32'h1);
        check("acc_valid", {31'h0, bus.instr_valid}, 32'h0);
        check("acc_trap_valid", {31'h0, bus.trap_valid}, {31'h0, trap});
        check("acc_trap_epc", bus.trap_epc, exp_epc);
    endtask

    initial begin
        logic [31:0] word;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.instr_ready = 1'b0;
        bus.pc_src = 1'b0;
        bus.imm_ext = 32'h0;

        // Reset held for 3 cycles
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_pc", bus.pc, 32'h0);
        check("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
        check("rst_req", {31'h0, bus.imem_req}, 32'h0);
        check("rst_instr", bus.instr, NOP);
        check("rst_opcode", {25'h0, bus.opcode}, 32'h13);
        check("rst_trap_valid", {31'h0, bus.trap_valid}, 32'h0);
        check("rst_trap_epc", bus.trap_epc, 32'h0);
        rst_n = 1'b1;
        tick();
        check("first_req", {31'h0, bus.imem_req}, 32'h1);
        check("first_addr", bus.imem_addr, 32'h0);

        // Sequential fetch of a branch word
        do_fetch(0, 32'h0000_0063);
        check("br_opcode", {25'h0, bus.opcode}, 32'h63);
        do_accept(1'b0, 32'h0);
        check("seq_addr", bus.imem_addr, 32'h4);

        // Wait states, then stall with ack/pc_src noise during HOLD
        word = $urandom;
        do_fetch(4, word);
        for (int k = 0; k < 5; k++) begin
            bus.imem_ack   = 1'($urandom);
            bus.imem_rdata = $urandom;
            tick();
            check("stall_instr", bus.instr, word);
            check("stall_pc", bus.pc, 32'h4);
            check("stall_valid", {31'h0, bus.instr_valid}, 32'h1);
        end
        bus.imem_ack = 1'b0;
        do_accept(1'b1, 32'h0000_000C);
        check("to_0x10", bus.imem_addr, 32'h10);

        // Taken backward branch
        do_fetch(1, $urandom);
        do_accept(1'b1, 32'hFFFF_FFF8);
        check("branch_addr", bus.imem_addr, 32'h8);

        // Reset during REQ with a late ack
        rst_n = 1'b0;
        tick();
        check("mid_rst_req", {31'h0, bus.imem_req}, 32'h0);
        check("mid_rst_pc", bus.pc, 32'h0);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("late_ack_instr", bus.instr, NOP);
        rst_n = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        check("restart_req", {31'h0, bus.imem_req}, 32'h1);
        check("restart_addr", bus.imem_addr, 32'h0);
        check("restart_instr", bus.instr, NOP);
        check("restart_valid", {31'h0, bus.instr_valid}, 32'h0);
        exp_pc = 32'h0;
        exp_epc = 32'h0;

        // Misaligned target from pc 0 with imm 6
        do_fetch(0, $urandom);
        do_accept(1'b1, 32'h6);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_addr", bus.imem_addr, 32'h100);
        check("mis_epc", bus.trap_epc, 32'h6);
`else
        check("mis_addr", bus.imem_addr, 32'h4);
`endif
        tick();
        check("mis_pulse_end", {31'h0, bus.trap_valid}, 32'h0);
        check("mis_epc_hold", bus.trap_epc, exp_epc);

        // Wrap from FFFF_FFFC to 0
        do_fetch(0, $urandom);
        do_accept(1'b1, 32'hFFFF_FFFC - exp_pc);
        check("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
        do_fetch(0, $urandom);
        check("wrap_plus4", bus.pc_plus4, 32'h0);
        do_accept(1'b0, 32'h0);
        check("wrap_zero", bus.imem_addr, 32'h0);

        // Randomized traffic against the model
        for (int t = 0; t < 150; t++) begin
            logic [31:0] imm;
            word = $urandom;
            do_fetch(int'($urandom_range(0, 3)), word);
            repeat ($urandom_range(0, 3)) begin
                bus.imem_ack = 1'($urandom);
                tick();
                check("rnd_hold_instr", bus.instr, word);
                check("rnd_hold_pc", bus.pc, exp_pc);
            end
            bus.imem_ack = 1'b0;
            imm = $urandom;
            if ($urandom_range(0, 3) != 0) imm = imm & 32'hFFFF_FFFC;
            do_accept(1'($urandom), imm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential instruction-fetch front end of the single-cycle RISC-V core. Produces the decoded fields `opcode`, `func3` and `func7` consumed by `Control_Unit`, and consumes its `PCSrc` decision to choose the next PC. Owns the program counter and a request/acknowledge handshake to instruction memory. Holds each fetched instruction stable until the execute side accepts it.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded by reset.
- `TRAP_VEC`, default 32'h0000_0100: redirect target for a misaligned fetch. Used only with `FETCH_MISALIGN_TRAP_EN`.

Ports (clock and reset first):
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: fetch address, equal to `pc`.
- `imem_ack`  in  1: memory response; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32: fetched instruction word.
- `instr_valid`  out  1: registered instruction available.
- `instr_ready`  in  1: execute side accepts the instruction and the `pc_src`/`imm_ext` presented with it.
- `pc_src`  in  1: `PCSrc` from `Control_Unit`. 1 selects `pc + imm_ext`.
- `imm_ext`  in  32: sign-extended immediate.
- `pc`, `pc_plus4`  out  32: address of the held instruction, and that address + 4.
- `instr`  out  32: the held instruction.
- `opcode`  out  7: `instr[6:0]`.
- `func3`  out  3: `instr[14:12]`.
- `func7`  out  7: `instr[31:25]`.
- `rd`, `rs1`, `rs2`  out  5 each: `instr[11:7]`, `instr[19:15]`, `instr[24:20]`.
- `trap_valid`  out  1: misaligned-target pulse (macro only; tied 0 otherwise).
- `trap_epc`  out  32: faulting target (macro only; tied 0 otherwise).

## Operation
- State machine with three states: `RESET`, `REQ`, `HOLD`.
- **`RESET`**
  - Entered whenever `rst_n`=0 at an edge.
  - Sets `pc`=`RESET_PC` and `instr`=32'h0000_0013 (NOP).
  - Drives `instr_valid`=0, `imem_req`=0, `trap_valid`=0, `trap_epc`=0.
  - Moves to `REQ` on the first edge with `rst_n`=1.
- **`REQ`**
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On an edge with `imem_ack`=1: register `imem_rdata` into `instr`, go to `HOLD`.
- **`HOLD`**
  - `instr_valid`=1; `instr`, `pc` and all field outputs are stable.
  - On an edge with `instr_ready`=1:
    - `pc` ← `pc_src` ? `pc + imm_ext` : `pc + 4`.
    - Go to `REQ`.
- **Arithmetic:** all PC arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- **Ignored inputs:**
  - `imem_ack` outside `REQ` is ignored.
  - `instr_ready` outside `HOLD` is ignored.
  - `pc_src` and `imm_ext` are sampled only on the accept edge.
- **Reset mid-operation:** the outstanding request is abandoned. `imem_req` is low from the next edge, and a late `imem_ack` is ignored.
- **Field outputs:** combinational slices of `instr`. They show the NOP fields while in `RESET`.

## Timing
- First request: `imem_req` asserts in the cycle after the first edge with `rst_n`=1.
- Fetch latency: `imem_ack` at edge N → `instr_valid`=1 from N+1.
- Redirect latency: accept at edge M → new `pc` and `imem_req`=1 from M+1.
- Best case, zero-wait memory: one instruction every 2 cycles.
- `instr_valid` and `imem_req` are never high together.

## Configuration
- Macro `FETCH_MISALIGN_TRAP_EN` defined:
  - On accept, if the selected next PC has bits [1:0] ≠ 0:
    - `pc` ← `TRAP_VEC`.
    - `trap_epc` ← the faulting target; it holds until the next trap or reset.
    - `trap_valid` pulses for exactly one cycle, M+1.
- Macro undefined:
  - Next-PC bits [1:0] are forced to 0.
  - `trap_valid` and `trap_epc` are constant 0.

## Structure
- Shared package `riscv_fetch_pkg` holds:
  - the state encoding (`RESET`, `REQ`, `HOLD`);
  - `NOP_INSTR` = 32'h0000_0013;
  - the field bit positions;
  - the opcode constants shared with `Control_Unit` (e.g. `OP_BRANCH` = 7'b1100011).
- One sub-module: `fetch_pc_next`. It is combinational: next-PC select, +4 and +imm adders, misalign detect.
- The FSM and the registers stay in `instr_fetch_unit`.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → `pc`=0, `instr_valid`=0, `imem_req`=0. Release → `imem_req`=1 with `imem_addr`=0 one cycle later.
- **Sequential fetch:** `imem_ack` with `imem_rdata`=32'h0000_0063 → `instr_valid`=1, `opcode`=7'b1100011, `func3`=0, `func7`=0. Accept with `pc_src`=0 → next `imem_addr`=4.
- **Taken branch:** `pc`=32'h10, `pc_src`=1, `imm_ext`=32'hFFFF_FFF8 → next `imem_addr`=32'h8.
- **Stall and wait states:** `instr_ready`=0 for 5 cycles → `instr` and `pc` unchanged. `imem_ack` delayed 4 cycles → `instr_valid` stays 0 throughout.
- **Reset during `REQ` with late ack:** `rst_n`=0 during `REQ`, then `imem_ack`=1 → `instr` stays NOP and the FSM restarts at `RESET_PC`.
- **Misaligned target:** `pc`=0, `pc_src`=1, `imm_ext`=6 → with macro: `trap_valid` 1-cycle pulse, `trap_epc`=6, next `imem_addr`=32'h100. Without macro: next `imem_addr`=4.
